// File: rtl/stream_arb_pkg.sv
// Shared types and helpers for the round-robin stream arbiter.
package stream_arb_pkg;

  localparam int unsigned N_INP_DEF     = 4;
  localparam int unsigned IDX_WIDTH_DEF = $clog2(N_INP_DEF);

  typedef logic [IDX_WIDTH_DEF-1:0] idx_t;

  // Modulo-n increment of a priority pointer.
  function automatic logic [31:0] rr_next(input logic [31:0] idx, input logic [31:0] n);
    logic [31:0] inc;
    inc = idx + 32'd1;
    return (inc >= n) ? 32'd0 : inc;
  endfunction

endpackage

// File: rtl/rr_prio_select.sv
// Combinational round-robin priority scan: first valid at or above the
// pointer wins, wrapping modulo N_INP.
module rr_prio_select
  import stream_arb_pkg::*;
#(
  parameter int unsigned N_INP     = 4,
  parameter int unsigned IDX_WIDTH = $clog2(N_INP)
) (
  input  logic [N_INP-1:0]     valid_i,
  input  logic [IDX_WIDTH-1:0] rr_i,
  output logic [IDX_WIDTH-1:0] winner_o,
  output logic                 any_req_o
);

  // Scan requesters starting at the pointer and keep the first hit.
  always_comb begin
    logic found;
    found     = 1'b0;
    winner_o  = '0;
    any_req_o = |valid_i;
    for (int i = 0; i < int'(N_INP); i++) begin
      int j;
      j = int'(rr_i) + i;
      if (j >= int'(N_INP)) j = j - int'(N_INP);
      if (!found && valid_i[j]) begin
        found    = 1'b1;
        winner_o = IDX_WIDTH'(j);
      end
    end
  end

endmodule

// File: rtl/stream_rr_arbiter_ft.sv
// Round-robin arbiter merging N_INP valid/ready streams into one, with a
// one-entry fall-through output stage. The winner index travels with data.
module stream_rr_arbiter_ft
  import stream_arb_pkg::*;
#(
  parameter int unsigned N_INP      = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned IDX_WIDTH  = $clog2(N_INP)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        clr_i,
  input  logic                        testmode_i,
  input  logic [N_INP-1:0]            inp_valid_i,
  output logic [N_INP-1:0]            inp_ready_o,
  input  logic [N_INP*DATA_WIDTH-1:0] inp_data_i,
  output logic                        oup_valid_o,
  input  logic                        oup_ready_i,
  output logic [DATA_WIDTH-1:0]       oup_data_o,
  output logic [IDX_WIDTH-1:0]        oup_idx_o
);

  logic                  full_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [IDX_WIDTH-1:0]  idx_q;
  logic [IDX_WIDTH-1:0]  rr_q;

  logic [IDX_WIDTH-1:0]  winner;
  logic                  any_req;
  logic [DATA_WIDTH-1:0] win_data;
  logic                  push;
  logic                  testmode_unused;

  assign testmode_unused = testmode_i;

  rr_prio_select #(
    .N_INP     (N_INP),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_sel (
    .valid_i   (inp_valid_i),
    .rr_i      (rr_q),
    .winner_o  (winner),
    .any_req_o (any_req)
  );

  // Select the winning requester's payload.
  always_comb begin
    win_data = '0;
    for (int k = 0; k < int'(N_INP); k++) begin
      if (winner == IDX_WIDTH'(k)) win_data = inp_data_i[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Output mux and upstream handshake: held beat when full, else fall-through.
  always_comb begin
    inp_ready_o = '0;
    oup_valid_o = 1'b0;
    oup_data_o  = '0;
    oup_idx_o   = '0;
    push        = 1'b0;
    if (full_q) begin
      oup_valid_o = 1'b1;
      oup_data_o  = data_q;
      oup_idx_o   = idx_q;
    end else if (any_req) begin
      oup_valid_o = 1'b1;
      oup_data_o  = win_data;
      oup_idx_o   = winner;
      push        = 1'b1;
      for (int k = 0; k < int'(N_INP); k++) begin
        if (winner == IDX_WIDTH'(k)) inp_ready_o[k] = 1'b1;
      end
    end
    // A flush cycle neither accepts nor presents a beat.
    if (clr_i) begin
      inp_ready_o = '0;
      oup_valid_o = 1'b0;
      push        = 1'b0;
    end
  end

  // Stage occupancy, captured beat and priority pointer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full_q <= 1'b0;
      data_q <= '0;
      idx_q  <= '0;
      rr_q   <= '0;
    end else if (clr_i) begin
      full_q <= 1'b0;
      rr_q   <= '0;
    end else if (full_q) begin
      if (oup_ready_i) full_q <= 1'b0;
    end else if (push) begin
      rr_q <= IDX_WIDTH'(rr_next(32'(winner), 32'(N_INP)));
      if (!oup_ready_i) begin
        full_q <= 1'b1;
        data_q <= win_data;
        idx_q  <= winner;
      end
    end
  end

endmodule

// File: tb/tb_stream_rr_arbiter_ft.sv
// Directed bench for stream_rr_arbiter_ft with hand-computed expectations.
module tb_stream_rr_arbiter_ft;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            clr;
  logic            testmode;
  logic [N-1:0]    inp_valid;
  logic [N-1:0]    inp_ready;
  logic [N*DW-1:0] inp_data;
  logic            oup_valid;
  logic            oup_ready;
  logic [DW-1:0]   oup_data;
  logic [IW-1:0]   oup_idx;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  stream_rr_arbiter_ft #(.N_INP(N), .DATA_WIDTH(DW)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .clr_i       (clr),
    .testmode_i  (testmode),
    .inp_valid_i (inp_valid),
    .inp_ready_o (inp_ready),
    .inp_data_i  (inp_data),
    .oup_valid_o (oup_valid),
    .oup_ready_i (oup_ready),
    .oup_data_o  (oup_data),
    .oup_idx_o   (oup_idx)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check all output-side signals after inputs settle.
  task automatic check_out(input string tag, input logic v, input logic [N-1:0] rdy,
                           input logic [IW-1:0] idx, input logic [DW-1:0] d);
    #1;
    check({tag, ".valid"}, 64'(oup_valid), 64'(v));
    check({tag, ".ready"}, 64'(inp_ready), 64'(rdy));
    check({tag, ".idx"},   64'(oup_idx),   64'(idx));
    check({tag, ".data"},  64'(oup_data),  64'(d));
  endtask

  initial begin
    rst_n     = 1'b0;
    clr       = 1'b0;
    testmode  = 1'b0;
    inp_valid = '0;
    oup_ready = 1'b0;
    for (int k = 0; k < N; k++) inp_data[k*DW +: DW] = 32'hA5A5_0000 + 32'(k);

    // Reset state
    #12;
    check_out("reset", 1'b0, 4'b0000, 2'd0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Fair rotation, all requesting, downstream always ready
    inp_valid = 4'b1111;
    oup_ready = 1'b1;
    check_out("rot0", 1'b1, 4'b0001, 2'd0, 32'hA5A5_0000);
    tick();
    check_out("rot1", 1'b1, 4'b0010, 2'd1, 32'hA5A5_0001);
    tick();
    check_out("rot2", 1'b1, 4'b0100, 2'd2, 32'hA5A5_0002);
    tick();
    check_out("rot3", 1'b1, 4'b1000, 2'd3, 32'hA5A5_0003);
    tick();

    // Stall: capture requester 2, hold while the input lane changes
    inp_valid = 4'b0100;
    oup_ready = 1'b0;
    check_out("cap", 1'b1, 4'b0100, 2'd2, 32'hA5A5_0002);
    tick();
    inp_valid = 4'b0000;
    inp_data[2*DW +: DW] = 32'h0BAD_0002;
    for (int c = 1; c <= 3; c++) begin
      check_out("hold", 1'b1, 4'b0000, 2'd2, 32'hA5A5_0002);
      tick();
    end
    inp_data[2*DW +: DW] = 32'hA5A5_0002;
    oup_ready = 1'b1;
    check_out("pop", 1'b1, 4'b0000, 2'd2, 32'hA5A5_0002);
    tick();
    check_out("empty", 1'b0, 4'b0000, 2'd0, 32'h0);

    // Wrap: pointer is 3, requesters 0 and 1
    inp_valid = 4'b0011;
    check_out("wrap0", 1'b1, 4'b0001, 2'd0, 32'hA5A5_0000);
    tick();
    check_out("wrap1", 1'b1, 4'b0010, 2'd1, 32'hA5A5_0001);
    tick();

    // Pop and request in the same cycle: pop only
    inp_valid = 4'b0001;
    oup_ready = 1'b0;
    check_out("cap0", 1'b1, 4'b0001, 2'd0, 32'hA5A5_0000);
    tick();
    inp_valid = 4'b1000;
    oup_ready = 1'b1;
    check_out("poponly", 1'b1, 4'b0000, 2'd0, 32'hA5A5_0000);
    tick();
    check_out("after_pop", 1'b1, 4'b1000, 2'd3, 32'hA5A5_0003);
    tick();

    // Flush while full; pointer returns to 0
    inp_valid = 4'b0100;
    oup_ready = 1'b0;
    check_out("cap2", 1'b1, 4'b0100, 2'd2, 32'hA5A5_0002);
    tick();
    inp_valid = 4'b0000;
    clr = 1'b1;
    #1;
    check("clr.valid", 64'(oup_valid), 64'd0);
    check("clr.ready", 64'(inp_ready), 64'd0);
    tick();
    clr = 1'b0;
    check_out("post_clr", 1'b0, 4'b0000, 2'd0, 32'h0);
    inp_valid = 4'b1010;
    oup_ready = 1'b1;
    check_out("clr_rr", 1'b1, 4'b0010, 2'd1, 32'hA5A5_0001);
    tick();

    // Asynchronous reset mid-stall
    inp_valid = 4'b0010;
    oup_ready = 1'b0;
    tick();
    inp_valid = 4'b0000;
    check_out("stall", 1'b1, 4'b0000, 2'd1, 32'hA5A5_0001);
    #1;
    rst_n = 1'b0;
    check_out("async_rst", 1'b0, 4'b0000, 2'd0, 32'h0);
    #3;
    rst_n = 1'b1;
    tick();
    inp_valid = 4'b1111;
    oup_ready = 1'b1;
    check_out("rst_restart", 1'b1, 4'b0001, 2'd0, 32'hA5A5_0000);
    tick();
    inp_valid = 4'b0000;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
